// File: rtl/mult_pkg.sv
// Shared multiplier widths: product width, final-adder segment width, stage count.
// Pure constants, no logic.
// Used by the compressor tree and the final carry-propagate adder.
package mult_pkg;
    localparam int PROD_WIDTH = 32;
    localparam int SEG_WIDTH  = 16;
    localparam int N_STAGES   = PROD_WIDTH / SEG_WIDTH;
endpackage

// File: rtl/seg_adder.sv
// One carry-propagate segment of the final adder.
// Latency: combinational.
// Backpressure: none (pure datapath).
module seg_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
endmodule

// File: rtl/wallace_final_adder.sv
// Segmented pipelined adder of the compressor-tree sum/carry rows; WALLACE_FINAL_ADDER_SKID_EN adds an input skid.
// Latency: WIDTH/SEG register stages (one segment of the carry chain per stage).
// Backpressure: whole pipeline holds while out_valid && !out_ready; skid build registers in_ready.
module wallace_final_adder
    import mult_pkg::*;
#(
    parameter int WIDTH = PROD_WIDTH,
    parameter int SEG   = SEG_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_s,
    input  logic [WIDTH-1:0] row_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
);
    localparam int N = WIDTH / SEG;

    // Stage k registers: skewed rows, partial result (segments 0..k), carry out of segment k.
    logic [WIDTH-1:0] st_s  [N];
    logic [WIDTH-1:0] st_c  [N];
    logic [WIDTH-1:0] st_r  [N];
    logic             st_cy [N];
    logic             st_v  [N];

    logic [WIDTH-1:0] prev_s  [N];
    logic [WIDTH-1:0] prev_c  [N];
    logic [WIDTH-1:0] prev_r  [N];
    logic             prev_cy [N];
    logic             prev_v  [N];
    logic [SEG-1:0]   seg_sum [N];
    logic             seg_cout[N];
    logic [WIDTH-1:0] res_nxt [N];

    logic [WIDTH-1:0] src_s;
    logic [WIDTH-1:0] src_c;
    logic             src_v;
    logic             adv;

    assign adv = !st_v[N-1] || out_ready;

`ifdef WALLACE_FINAL_ADDER_SKID_EN
    logic             skid_v;
    logic [WIDTH-1:0] skid_s;
    logic [WIDTH-1:0] skid_c;
    logic             accept;

    assign in_ready = !skid_v;
    assign accept   = in_valid && !skid_v;
    // A parked word always enters the pipeline before anything new.
    assign src_v    = skid_v || accept;
    assign src_s    = skid_v ? skid_s : row_s;
    assign src_c    = skid_v ? skid_c : row_c;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            skid_v <= 1'b0;
            skid_s <= '0;
            skid_c <= '0;
        end else if (adv) begin
            skid_v <= 1'b0;
        end else if (accept) begin
            skid_v <= 1'b1;
            skid_s <= row_s;
            skid_c <= row_c;
        end
    end
`else
    assign in_ready = adv;
    assign src_v    = in_valid;
    assign src_s    = row_s;
    assign src_c    = row_c;
`endif

    for (genvar k = 0; k < N; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign prev_s[k]  = src_s;
            assign prev_c[k]  = src_c;
            assign prev_r[k]  = '0;
            assign prev_cy[k] = 1'b0;
            assign prev_v[k]  = src_v;
        end else begin : g_body
            assign prev_s[k]  = st_s[k-1];
            assign prev_c[k]  = st_c[k-1];
            assign prev_r[k]  = st_r[k-1];
            assign prev_cy[k] = st_cy[k-1];
            assign prev_v[k]  = st_v[k-1];
        end

        seg_adder #(.W(SEG)) u_add (
            .a    (prev_s[k][k*SEG +: SEG]),
            .b    (prev_c[k][k*SEG +: SEG]),
            .cin  (prev_cy[k]),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k])
        );

        // Segment k of the partial result is still zero here, so OR-ing it in is enough.
        assign res_nxt[k] = prev_r[k] | (WIDTH'(seg_sum[k]) << (k * SEG));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int k = 0; k < N; k++) begin
                st_v[k]  <= 1'b0;
                st_s[k]  <= '0;
                st_c[k]  <= '0;
                st_r[k]  <= '0;
                st_cy[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < N; k++) begin
                st_v[k]  <= prev_v[k];
                st_s[k]  <= prev_s[k];
                st_c[k]  <= prev_c[k];
                st_r[k]  <= res_nxt[k];
                st_cy[k] <= seg_cout[k];
            end
        end
    end

    // The last stage's rows and carry-out have no consumer: the sum wraps modulo 2^WIDTH.
    logic unused_tail;
    assign unused_tail = ^{st_s[N-1], st_c[N-1], st_cy[N-1]};

    assign out_valid = st_v[N-1];
    assign product   = st_r[N-1];
endmodule

// File: tb/tb_wallace_final_adder.sv
// Bench for wallace_final_adder: directed vectors, corner sequences, randomized scoreboard.
module tb_wallace_final_adder;
    import mult_pkg::*;

    localparam int W = PROD_WIDTH;
    localparam int N = N_STAGES;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] row_s;
    logic [W-1:0] row_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    wallace_final_adder dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_s     (row_s),
        .row_c     (row_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    typedef struct {
        string        name;
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         vt[6];
    logic [W-1:0] ss[4];
    logic [W-1:0] cc[4];
    logic [W-1:0] ee[4];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_prod;
    logic [W-1:0] hold_prod;
    logic [W-1:0] want;
    logic         acc, ret, hold;

    initial begin
        vt[0] = '{"cross_seg", 32'h0000FFFF, 32'h00000001, 32'h00010000};
        vt[1] = '{"wrap",      32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vt[2] = '{"zero",      32'h00000000, 32'h00000000, 32'h00000000};
        vt[3] = '{"msb_wrap",  32'h80000000, 32'h80000000, 32'h00000000};
        vt[4] = '{"mid_carry", 32'h00018000, 32'h00008000, 32'h00020000};
        vt[5] = '{"mixed",     32'hDEADBEEF, 32'h01234567, 32'hDFD10456};
        ss = '{32'h00000001, 32'h00000010, 32'hFFFF0000, 32'h12345678};
        cc = '{32'h00000002, 32'h00000020, 32'h00010000, 32'h11111111};
        ee = '{32'h00000003, 32'h00000030, 32'h00000000, 32'h23456789};

        sys_rst   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        row_s     = '0;
        row_c     = '0;
        tick;
        tick;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_product",   product,        32'h0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        sys_rst   = 1'b0;
        out_ready = 1'b1;

        // Single transactions: check latency and value.
        for (int i = 0; i < 6; i++) begin
            row_s    = vt[i].s;
            row_c    = vt[i].c;
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            chk({vt[i].name, "_early"}, 32'(out_valid), 32'd0);
            repeat (N - 2) tick;
            tick;
            chk({vt[i].name, "_vld"}, 32'(out_valid), 32'd1);
            chk({vt[i].name, "_val"}, product, vt[i].exp);
            tick;
            chk({vt[i].name, "_gone"}, 32'(out_valid), 32'd0);
        end

        // Back-to-back stream.
        for (int cyc = 0; cyc < 4 + N; cyc++) begin
            in_valid = (cyc < 4);
            if (cyc < 4) begin
                row_s = ss[cyc];
                row_c = cc[cyc];
            end
            tick;
            if (cyc - (N - 1) >= 0 && cyc - (N - 1) < 4) begin
                chk("stream_vld", 32'(out_valid), 32'd1);
                chk("stream_val", product, ee[cyc-(N-1)]);
            end else begin
                chk("stream_idle", 32'(out_valid), 32'd0);
            end
        end

        // Back-pressure: fill with A, B; stall 3 cycles with C offered; release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        row_s = 32'h00000001; row_c = 32'h00000002;
        tick;
        row_s = 32'h0000FFFF; row_c = 32'h0000FFFF;
        tick;
        row_s = 32'h0F0F0F0F; row_c = 32'hF0F0F0F0;
        #1;
`ifndef WALLACE_FINAL_ADDER_SKID_EN
        chk("bp_in_ready", 32'(in_ready), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick;
`ifdef WALLACE_FINAL_ADDER_SKID_EN
            in_valid = 1'b0;
`else
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
`endif
            chk("bp_hold_vld", 32'(out_valid), 32'd1);
            chk("bp_hold_val", product, 32'h00000003);
        end
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("bp_rel_b_vld", 32'(out_valid), 32'd1);
        chk("bp_rel_b_val", product, 32'h0001FFFE);
        tick;
        chk("bp_rel_c_vld", 32'(out_valid), 32'd1);
        chk("bp_rel_c_val", product, 32'hFFFFFFFF);
        tick;
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two transactions in flight.
        in_valid = 1'b1;
        row_s = 32'h00001234; row_c = 32'h00004321;
        tick;
        row_s = 32'hAAAA0000; row_c = 32'h5555FFFF;
        tick;
        sys_rst  = 1'b1;
        in_valid = 1'b0;
        tick;
        chk("rst_mid_vld",      32'(out_valid), 32'd0);
        chk("rst_mid_product",  product,        32'h0);
        chk("rst_mid_in_ready", 32'(in_ready),  32'd1);
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rst_mid_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic against a queue-based reference.
        hold = 1'b0;
        hold_prod = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (hold) begin
                chk("rnd_hold_vld", 32'(out_valid), 32'd1);
                chk("rnd_hold_val", product, hold_prod);
            end
            if (cyc < 650) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            row_s = $urandom;
            row_c = ($urandom_range(0, 3) == 0) ? (~row_s + W'(1)) : W'($urandom);
            #1;
`ifndef WALLACE_FINAL_ADDER_SKID_EN
            chk("rnd_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
`endif
            acc       = in_valid && in_ready;
            ret       = out_valid && out_ready;
            cur_prod  = product;
            hold      = out_valid && !out_ready;
            hold_prod = product;
            want      = row_s + row_c;
            tick;
            if (ret) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious_out", 32'd1, 32'd0);
                end else begin
                    chk("rnd_product", cur_prod, exp_q.pop_front());
                end
            end
            if (acc) exp_q.push_back(want);
        end
        chk("rnd_all_retired", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wallace_final_adder.md
# wallace_final_adder

Pipelined carry-propagate adder forming the last stage of the Booth-4 Wallace 16×16 multiplier. It accepts the two redundant rows (sum row, carry row) from the final layer of 4:2 / 3:2 compressors and adds them into the binary product. The carry chain is split into SEG-bit segments, one per pipeline stage, to cut the critical path. A valid/ready handshake on both sides allows back-pressure from the consumer.

## Interface
Parameters:
- WIDTH, 32, width of both input rows and of the product
- SEG, 16, segment width per pipeline stage; WIDTH % SEG == 0; N = WIDTH/SEG stages

Ports:
- sys_clk  input  1  single clock; all state on rising edge
- sys_rst  input  1  reset, synchronous, active-high
- in_valid  input  1  row_s/row_c valid
- in_ready  output  1  block can accept this cycle
- row_s  input  WIDTH  sum row from compressor tree, bit-aligned
- row_c  input  WIDTH  carry row from compressor tree, already shifted to product weight
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  WIDTH  (row_s + row_c) mod 2^WIDTH

## Operation
- Accept on in_valid && in_ready at a rising edge.
- Stage k (0..N-1) adds segment k of both rows (bits k*SEG+SEG-1 : k*SEG) plus the registered carry from stage k-1; stage 0 carry-in = 0.
- Segments not yet added are carried forward unchanged in skew registers; finished segments are forwarded alongside in result registers.
- Carry-out of stage N-1 is discarded (wrap modulo 2^WIDTH); no overflow flag.
- Per-stage valid bit; bubbles propagate as invalid stages.
- Global advance: adv = !out_valid || out_ready. When adv=1, every stage shifts one position; when adv=0, all stages hold.
- in_ready = adv (combinational from out_ready, without the configuration macro).
- Order strictly preserved; no reordering, no dropping.

## Timing
- Reset (sys_rst=1 at an edge): all valid bits 0, all data registers 0; after reset out_valid=0, product=0, in_ready=1.
- Latency: a transaction accepted at edge t appears with out_valid=1 after edge t+N-1 (N=2: visible the cycle after acceptance edge's next edge, i.e. two register stages).
- Throughput: one transaction per cycle when out_ready held high.
- Back-pressure: while out_valid=1 && out_ready=0, product and out_valid stable; in_ready=0; in-flight stages hold.
- Simultaneous out_ready and in_valid on a full pipeline: output retires and new input enters in the same edge.
- Reset mid-operation: in-flight transactions discarded; no stale out_valid after reset.
- in_valid while in_ready=0: ignored, no state change; upstream must hold data.

## Configuration
- WALLACE_FINAL_ADDER_SKID_EN defined: one-entry skid buffer added at the input; in_ready becomes a register output (= skid buffer empty), removing the combinational out_ready→in_ready path. On stall with incoming accept, the word is parked in the skid and injected first when adv returns. Latency unchanged when not stalled; throughput 1/cycle sustained; reset clears the skid (in_ready=1 after reset).
- Not defined: no skid; in_ready = adv as above.

## Structure
- Shared package mult_pkg: PROD_WIDTH=32, SEG_WIDTH=16, N_STAGES derived constant; reused by compressor-tree top for row widths.
- One sub-module: seg_adder (combinational SEG-bit adder, inputs a, b, cin; outputs sum, cout); instantiated N times inside a generate loop. Pipeline registers and handshake live in wallace_final_adder.

## Test plan
- Reset: hold sys_rst 2 cycles -> out_valid=0, product=0x00000000, in_ready=1.
- Cross-segment carry: row_s=0x0000FFFF, row_c=0x00000001 -> product=0x00010000 after latency N.
- Wrap: row_s=0xFFFFFFFF, row_c=0x00000001 -> product=0x00000000, out_valid=1.
- Streaming: 4 back-to-back inputs (0x1+0x2, 0x10+0x20, 0xFFFF0000+0x00010000, 0x12345678+0x11111111), out_ready=1 -> outputs 0x3, 0x30, 0x00000000, 0x23456789 on consecutive cycles.
- Back-pressure: pipeline full, out_ready=0 for 3 cycles -> product stable, in_ready=0, no loss; releasing gives all results in order.
- Reset mid-flight: sys_rst asserted with 2 transactions in flight -> next cycle out_valid=0, product=0; no result emerges afterwards.
